// File: rtl/sram_controller_if.sv
// rtl/sram_controller_if.sv - MEM-stage load/store port between the pipeline and sram_controller
interface sram_controller_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        err;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready, err
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready, err
    );
endinterface

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit load/store port to 16-bit SRAM, two halfword accesses per word
// Optional out-of-range rejection: define SRAM_CTRL_RANGE_CHECK_EN
module sram_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 1,
    parameter int MEM_WORDS   = 256
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [17:0]        SRAM_ADDR,
    output logic               SRAM_WE_N
);
    typedef enum logic [2:0] {
        IDLE,
        ACC_LO,
        ACC_HI,
        CAP_HI,
        WAIT,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        op_wr;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [3:0]  wait_cnt;
    logic [31:0] offset;
    logic        req;
    logic        out_of_range;
    logic        dq_oe;
    logic [15:0] dq_out;
    logic        unused_bits;

    assign req    = bus.wr_en | bus.rd_en;
    assign offset = bus.address - 32'(BASE_ADDR);
    assign unused_bits = ^{offset[31:19], offset[1:0]};

`ifdef SRAM_CTRL_RANGE_CHECK_EN
    logic err_q;

    assign out_of_range = (bus.address < 32'(BASE_ADDR)) | (offset[31:2] >= 30'(MEM_WORDS));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == IDLE && req) begin
            err_q <= out_of_range;
        end
    end

    assign bus.err = err_q & (state == DONE);
`else
    logic [31:0] unused_words;

    assign unused_words = 32'(MEM_WORDS);
    assign out_of_range = 1'b0;
    assign bus.err      = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = out_of_range ? DONE : ACC_LO;
            ACC_LO:  state_nxt = ACC_HI;
            ACC_HI:  state_nxt = CAP_HI;
            CAP_HI:  state_nxt = (WAIT_CYCLES == 0) ? DONE : WAIT;
            WAIT:    if (wait_cnt == 4'(WAIT_CYCLES - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The SRAM returns data one cycle after the address, so the low half lands during ACC_HI.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_wr     <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            wait_cnt  <= '0;
            SRAM_ADDR <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req) begin
                        op_wr   <= bus.wr_en;
                        wdata_q <= bus.write_data;
                        if (!out_of_range) begin
                            SRAM_ADDR <= {offset[18:2], 1'b0};
                        end else if (!bus.wr_en) begin
                            rdata_q <= '0;
                        end
                    end
                end
                ACC_LO: SRAM_ADDR[0] <= 1'b1;
                ACC_HI: if (!op_wr) rdata_q[15:0] <= SRAM_DQ;
                CAP_HI: begin
                    if (!op_wr) rdata_q[31:16] <= SRAM_DQ;
                    wait_cnt <= '0;
                end
                WAIT:   wait_cnt <= wait_cnt + 4'd1;
                default: ;
            endcase
        end
    end

    assign dq_oe     = op_wr & ((state == ACC_LO) | (state == ACC_HI));
    assign dq_out    = (state == ACC_LO) ? wdata_q[15:0] : wdata_q[31:16];
    assign SRAM_DQ   = dq_oe ? dq_out : 16'bz;
    assign SRAM_WE_N = ~dq_oe;

    assign bus.read_data = rdata_q;
    assign bus.ready     = (state == DONE) | ((state == IDLE) & ~req);
endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - directed self-checking bench for sram_controller
module tb_sram_controller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_controller_if bus();
    sram_controller_if b0();
    sram_controller_if b3();

    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    wire  [15:0] dq0;
    wire  [15:0] dq3;
    logic [17:0] addr0, addr3;
    logic        we0, we3;

    sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(1), .MEM_WORDS(256)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n)
    );
    sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(0), .MEM_WORDS(256)) dut_w0 (
        .clk(clk), .rst(rst), .bus(b0.slave),
        .SRAM_DQ(dq0), .SRAM_ADDR(addr0), .SRAM_WE_N(we0)
    );
    sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(3), .MEM_WORDS(256)) dut_w3 (
        .clk(clk), .rst(rst), .bus(b3.slave),
        .SRAM_DQ(dq3), .SRAM_ADDR(addr3), .SRAM_WE_N(we3)
    );

    // Synchronous SRAM model: one cycle read latency, drives DQ only when the bench enables it.
    logic [15:0] mem [0:262143];
    logic [15:0] sram_q;
    logic        sram_oe;
    always @(posedge clk) begin
        if (sram_we_n === 1'b0) mem[sram_addr] <= sram_dq;
        sram_q <= mem[sram_addr];
    end
    assign sram_dq = (sram_oe && sram_we_n) ? sram_q : 16'bz;

    int checks = 0;
    int fails  = 0;

    int          r_lat, r_drv, r_we;
    logic [17:0] r_a0, r_a1;
    logic [15:0] r_d0, r_d1;
    logic [31:0] r_rd;
    logic        r_err;

    function automatic logic released(input logic [15:0] v);
        return (v === 16'bz) || (v === 16'h0000);
    endfunction

    task automatic go_idle;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        sram_oe   = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge of the first cycle with ready=1, request still held.
    task automatic run_access(input logic is_wr, input logic [31:0] addr, input logic [31:0] data,
                              input logic oe);
        bus.wr_en = is_wr;
        bus.rd_en = !is_wr;
        bus.address = addr;
        bus.write_data = data;
        sram_oe = oe && !is_wr;
        r_lat = -1; r_drv = 0; r_we = 0;
        r_a0 = '1; r_a1 = '1; r_d0 = '0; r_d1 = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!sram_oe && !released(sram_dq)) r_drv++;
            if (sram_we_n !== 1'b1) r_we++;
            if (c == 1) begin r_a0 = sram_addr; r_d0 = sram_dq; end
            if (c == 2) begin r_a1 = sram_addr; r_d1 = sram_dq; end
            if (bus.ready) begin
                r_lat = c;
                r_rd  = bus.read_data;
                r_err = bus.err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.wr_en = 0; bus.rd_en = 0; bus.address = 0; bus.write_data = 0;
        b0.wr_en = 0; b0.rd_en = 0; b0.address = 0; b0.write_data = 0;
        b3.wr_en = 0; b3.rd_en = 0; b3.address = 0; b3.write_data = 0;
        sram_oe = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", bus.ready); end
        checks++; if (bus.read_data !== 32'h0) begin fails++; $display("FAIL reset_read_data: got %h expected 0", bus.read_data); end
        checks++; if (bus.err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", bus.err); end
        checks++; if (sram_we_n !== 1'b1) begin fails++; $display("FAIL reset_we_n: got %b expected 1", sram_we_n); end
        checks++; if (sram_addr !== 18'h0) begin fails++; $display("FAIL reset_sram_addr: got %h expected 0", sram_addr); end
        checks++; if (!released(sram_dq)) begin fails++; $display("FAIL reset_dq: got %h expected released", sram_dq); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_bus_release;
        go_idle;
        run_access(1'b0, 32'd1032, 32'hA5A5_A5A5, 1'b0);
        checks++; if (r_lat !== 5) begin fails++; $display("FAIL release_latency: got %0d expected 5", r_lat); end
        checks++; if (r_drv !== 0) begin fails++; $display("FAIL release_read_drive: got %0d cycles expected 0", r_drv); end
        checks++; if (r_we !== 0) begin fails++; $display("FAIL release_read_we: got %0d cycles expected 0", r_we); end
    endtask

    task automatic test_write_read;
        go_idle;
        run_access(1'b1, 32'd1024, 32'hDEAD_BEEF, 1'b0);
        checks++; if (r_lat !== 5) begin fails++; $display("FAIL wr_latency: got %0d expected 5", r_lat); end
        checks++; if (r_a0 !== 18'd0 || r_a1 !== 18'd1) begin fails++; $display("FAIL wr_addr: got %h,%h expected 0,1", r_a0, r_a1); end
        checks++; if (r_d0 !== 16'hBEEF || r_d1 !== 16'hDEAD) begin fails++; $display("FAIL wr_dq: got %h,%h expected beef,dead", r_d0, r_d1); end
        checks++; if (r_drv !== 2 || r_we !== 2) begin fails++; $display("FAIL wr_drive_cycles: got %0d/%0d expected 2/2", r_drv, r_we); end
        go_idle;
        checks++; if (mem[0] !== 16'hBEEF || mem[1] !== 16'hDEAD) begin fails++; $display("FAIL wr_mem: got %h,%h expected beef,dead", mem[0], mem[1]); end
        run_access(1'b0, 32'd1024, 32'hA5A5_A5A5, 1'b1);
        checks++; if (r_lat !== 5) begin fails++; $display("FAIL rd_latency: got %0d expected 5", r_lat); end
        checks++; if (r_rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_data: got %h expected deadbeef", r_rd); end
        checks++; if (r_we !== 0) begin fails++; $display("FAIL rd_we: got %0d cycles expected 0", r_we); end
    endtask

    task automatic test_back_to_back;
        go_idle;
        run_access(1'b1, 32'd1028, 32'h1234_5678, 1'b0);
        checks++; if (r_lat !== 5) begin fails++; $display("FAIL b2b_wr_latency: got %0d expected 5", r_lat); end
        checks++; if (r_a0 !== 18'd2 || r_a1 !== 18'd3) begin fails++; $display("FAIL b2b_wr_addr: got %h,%h expected 2,3", r_a0, r_a1); end
        run_access(1'b0, 32'd1028, 32'hA5A5_A5A5, 1'b1);
        checks++; if (r_lat !== 6) begin fails++; $display("FAIL b2b_rd_latency: got %0d expected 6", r_lat); end
        checks++; if (r_rd !== 32'h1234_5678) begin fails++; $display("FAIL b2b_rd_data: got %h expected 12345678", r_rd); end
        go_idle;
        run_access(1'b1, 32'd1036, 32'h0BAD_F00D, 1'b0);
        go_idle;
        checks++; if (bus.read_data !== 32'h1234_5678) begin fails++; $display("FAIL rd_data_hold: got %h expected 12345678", bus.read_data); end
    endtask

    task automatic test_reset_mid;
        go_idle;
        bus.rd_en = 1'b1; bus.address = 32'd1024; sram_oe = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; bus.rd_en = 1'b0; sram_oe = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.ready !== 1'b1) begin fails++; $display("FAIL midrst_ready: got %b expected 1", bus.ready); end
        checks++; if (bus.read_data !== 32'h0) begin fails++; $display("FAIL midrst_read_data: got %h expected 0", bus.read_data); end
        checks++; if (sram_we_n !== 1'b1 || sram_addr !== 18'h0) begin fails++; $display("FAIL midrst_sram: got we_n=%b addr=%h expected 1,0", sram_we_n, sram_addr); end
        checks++; if (!released(sram_dq)) begin fails++; $display("FAIL midrst_dq: got %h expected released", sram_dq); end
        @(negedge clk);
    endtask

    task automatic test_wait_cycles;
        int l0, l3;
        go_idle;
        b0.wr_en = 1'b1; b0.address = 32'd1024; b0.write_data = 32'h1111_2222;
        b3.wr_en = 1'b1; b3.address = 32'd1024; b3.write_data = 32'h3333_4444;
        l0 = -1; l3 = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (l0 < 0 && b0.ready) begin l0 = c; b0.wr_en = 1'b0; end
            if (l3 < 0 && b3.ready) begin l3 = c; b3.wr_en = 1'b0; end
        end
        checks++; if (l0 !== 4) begin fails++; $display("FAIL wait0_latency: got %0d expected 4", l0); end
        checks++; if (l3 !== 7) begin fails++; $display("FAIL wait3_latency: got %0d expected 7", l3); end
    endtask

`ifdef SRAM_CTRL_RANGE_CHECK_EN
    task automatic test_range_check;
        go_idle;
        run_access(1'b0, 32'd1028, 32'hA5A5_A5A5, 1'b1);
        checks++; if (r_rd !== 32'h1234_5678 || r_err !== 1'b0) begin fails++; $display("FAIL range_valid_rd: got %h err=%b expected 12345678 err=0", r_rd, r_err); end
        go_idle;
        run_access(1'b0, 32'd1020, 32'hA5A5_A5A5, 1'b1);
        checks++; if (r_lat !== 1) begin fails++; $display("FAIL range_low_latency: got %0d expected 1", r_lat); end
        checks++; if (r_err !== 1'b1 || r_rd !== 32'h0) begin fails++; $display("FAIL range_low: got err=%b data=%h expected 1,0", r_err, r_rd); end
        checks++; if (r_we !== 0) begin fails++; $display("FAIL range_low_we: got %0d cycles expected 0", r_we); end
        go_idle;
        checks++; if (bus.err !== 1'b0) begin fails++; $display("FAIL range_err_pulse: got %b expected 0", bus.err); end
        run_access(1'b1, 32'd2048, 32'hFFFF_FFFF, 1'b0);
        checks++; if (r_lat !== 1 || r_err !== 1'b1) begin fails++; $display("FAIL range_high: got lat=%0d err=%b expected 1,1", r_lat, r_err); end
        checks++; if (r_we !== 0 || r_drv !== 0) begin fails++; $display("FAIL range_high_bus: got we=%0d drv=%0d expected 0,0", r_we, r_drv); end
        go_idle;
        run_access(1'b1, 32'd2044, 32'h5555_6666, 1'b0);
        checks++; if (r_lat !== 5 || r_err !== 1'b0 || r_a1 !== 18'd511) begin fails++; $display("FAIL range_last_word: got lat=%0d err=%b addr=%h expected 5,0,1ff", r_lat, r_err, r_a1); end
    endtask
`else
    task automatic test_wrap;
        go_idle;
        run_access(1'b1, 32'd1020, 32'hCAFE_F00D, 1'b0);
        checks++; if (r_lat !== 5 || r_err !== 1'b0) begin fails++; $display("FAIL wrap_latency: got lat=%0d err=%b expected 5,0", r_lat, r_err); end
        checks++; if (r_a0 !== 18'h3FFFE || r_a1 !== 18'h3FFFF) begin fails++; $display("FAIL wrap_addr: got %h,%h expected 3fffe,3ffff", r_a0, r_a1); end
        go_idle;
        checks++; if (mem[18'h3FFFE] !== 16'hF00D || mem[18'h3FFFF] !== 16'hCAFE) begin fails++; $display("FAIL wrap_mem: got %h,%h expected f00d,cafe", mem[18'h3FFFE], mem[18'h3FFFF]); end
    endtask
`endif

    initial begin
        test_reset;
        test_bus_release;
        test_write_read;
        test_back_to_back;
        test_reset_mid;
        test_wait_cycles;
`ifdef SRAM_CTRL_RANGE_CHECK_EN
        test_range_check;
`else
        test_wrap;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
